// File: rtl/pool_scheduler_if.sv
// Memory read/write ports and the 2x2 window handshake between the pool
// scheduler (master) and the memories plus pooling unit (slave).
interface pool_scheduler_if #(
  parameter int DW = 8,
  parameter int AW = 12
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] p_data0;
  logic [DW-1:0] p_data1;
  logic [DW-1:0] p_data2;
  logic [DW-1:0] p_data3;
  logic          p_valid;
  logic          p_ready;
  logic [DW-1:0] p_ans;
  logic          p_ans_valid;
  logic          p_ans_ready;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output wr_en, wr_addr, wr_data,
    output p_data0, p_data1, p_data2, p_data3, p_valid,
    input  p_ready,
    input  p_ans, p_ans_valid,
    output p_ans_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  wr_en, wr_addr, wr_data,
    input  p_data0, p_data1, p_data2, p_data3, p_valid,
    output p_ready,
    output p_ans, p_ans_valid,
    input  p_ans_ready
  );
endinterface

// File: rtl/pool_scheduler.sv
// Walks a feature map in 2x2 windows: fetches four pixels, hands them to a
// pooling unit, and writes each pooled result to the output map in raster order.
//
// state | meaning
// IDLE  | waiting for start, cfg latched on start
// FETCH | four read strobes, k = 0..3
// CAPT  | capture k3 read data
// SEND  | offer window to pooling unit
// RESP  | wait for pooled result
// WRITE | write result to output map
// FIN   | one-cycle done pulse
module pool_scheduler #(
  parameter int DW   = 8,
  parameter int AW   = 12,
  parameter int DIMW = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DIMW-1:0]   cfg_w,
  input  logic [DIMW-1:0]   cfg_h,
  input  logic [AW-1:0]     cfg_src,
  input  logic [AW-1:0]     cfg_dst,
  output logic              busy,
  output logic              done,
  pool_scheduler_if.master  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] CAPT  = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;
  localparam logic [2:0] WRITE = 3'd5;
  localparam logic [2:0] FIN   = 3'd6;

  localparam logic [DIMW-2:0] ONE = 1;

  logic [2:0]      state;
  logic [1:0]      k;
  logic [DIMW-1:0] w_q;
  logic [DIMW-2:0] ow_q;
  logic [DIMW-2:0] oh_q;
  logic [DIMW-2:0] r;
  logic [DIMW-2:0] c;
  logic [AW-1:0]   rd_row;
  logic [AW-1:0]   wr_row;
  logic [DW-1:0]   pd0, pd1, pd2, pd3;
  logic [DW-1:0]   ans_q;

  logic            empty_map;
  logic            c_last;
  logic            r_last;
  logic [AW-1:0]   fetch_addr;

  // A dimension below 2 leaves no complete window in that direction.
  assign empty_map = (cfg_w < DIMW'(2)) || (cfg_h < DIMW'(2));
  assign c_last    = (c == ow_q - ONE);
  assign r_last    = (r == oh_q - ONE);

  // rd_row/wr_row track the top-left pixel row and output row of window row r,
  // so addresses need only adds; everything wraps modulo 2^AW.
  assign fetch_addr = rd_row
                    + (k[1] ? AW'(w_q) : '0)
                    + AW'({c, 1'b0})
                    + AW'(k[0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      k      <= '0;
      w_q    <= '0;
      ow_q   <= '0;
      oh_q   <= '0;
      r      <= '0;
      c      <= '0;
      rd_row <= '0;
      wr_row <= '0;
      pd0    <= '0;
      pd1    <= '0;
      pd2    <= '0;
      pd3    <= '0;
      ans_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w_q    <= cfg_w;
            ow_q   <= cfg_w[DIMW-1:1];
            oh_q   <= cfg_h[DIMW-1:1];
            rd_row <= cfg_src;
            wr_row <= cfg_dst;
            r      <= '0;
            c      <= '0;
            k      <= '0;
            state  <= empty_map ? FIN : FETCH;
          end
        end
        FETCH: begin
          // Read data trails the strobe by one cycle, so k captures slot k-1.
          case (k)
            2'd1:    pd0 <= bus.rd_data;
            2'd2:    pd1 <= bus.rd_data;
            2'd3:    pd2 <= bus.rd_data;
            default: ;
          endcase
          k <= k + 2'd1;
          if (k == 2'd3) state <= CAPT;
        end
        CAPT: begin
          pd3   <= bus.rd_data;
          state <= SEND;
        end
        SEND: begin
          if (bus.p_ready) state <= RESP;
        end
        RESP: begin
          if (bus.p_ans_valid) begin
            ans_q <= bus.p_ans;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (c_last) begin
            c <= '0;
            if (r_last) begin
              state <= FIN;
            end else begin
              r      <= r + ONE;
              rd_row <= rd_row + AW'({w_q, 1'b0});
              wr_row <= wr_row + AW'(ow_q);
              state  <= FETCH;
            end
          end else begin
            c     <= c + ONE;
            state <= FETCH;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == FETCH) || (state == CAPT) || (state == SEND) ||
                (state == RESP)  || (state == WRITE);
  assign done = (state == FIN);

  assign bus.rd_en       = (state == FETCH);
  assign bus.rd_addr     = (state == FETCH) ? fetch_addr : '0;
  assign bus.wr_en       = (state == WRITE);
  assign bus.wr_addr     = (state == WRITE) ? (wr_row + AW'(c)) : '0;
  assign bus.wr_data     = ans_q;
  assign bus.p_data0     = pd0;
  assign bus.p_data1     = pd1;
  assign bus.p_data2     = pd2;
  assign bus.p_data3     = pd3;
  assign bus.p_valid     = (state == SEND);
  assign bus.p_ans_ready = (state == RESP);

endmodule

// File: doc/pool_scheduler.md
POOL_SCHEDULER -- requirements
Module: pool_scheduler

Interface
REQ-001 The block SHALL have these parameters:
- DW, 8, pixel/result width
- AW, 12, memory address width
- DIMW, 7, width of the dimension fields
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, and no other clock or reset.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  run request, sampled only in IDLE
- cfg_w, cfg_h  in  DIMW  feature-map width/height in pixels
- cfg_src, cfg_dst  in  AW  input map base / output map base
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- rd_en  out  1  input-memory read strobe
- rd_addr  out  AW  read address
- rd_data  in  DW  read data, valid the cycle after rd_en
- wr_en  out  1  output-memory write strobe
- wr_addr  out  AW  write address
- wr_data  out  DW  write data
- p_data0..p_data3  out  DW each  2x2 window to pooling unit
- p_valid  out  1  window valid
- p_ready  in  1  pooling unit accepts window
- p_ans  in  DW  pooled result
- p_ans_valid  in  1  result valid
- p_ans_ready  out  1  scheduler accepts result

Function
REQ-004 In IDLE, start=1 SHALL latch all cfg_* inputs; cfg changes during a run SHALL have no effect.
REQ-005 Window grid SHALL be OW=floor(cfg_w/2), OH=floor(cfg_h/2); a trailing odd row or column SHALL be ignored.
REQ-006 If OW=0 or OH=0, the block SHALL pulse done the cycle after start, with no rd_en, p_valid or wr_en.
REQ-007 Windows SHALL be processed in raster order: r = 0..OH-1 outer, c = 0..OW-1 inner.
REQ-008 The state machine SHALL have states IDLE, FETCH, CAPT, SEND, RESP, WRITE, FIN.
REQ-009 FETCH SHALL last exactly 4 cycles with rd_en=1, issuing k=0..3 in this order:
- k0: src+(2r)*W+2c
- k1: src+(2r)*W+2c+1
- k2: src+(2r+1)*W+2c
- k3: src+(2r+1)*W+2c+1
Here W is the latched cfg_w, and all address arithmetic is modulo 2^AW.
REQ-010 rd_data returned for k0..k3 SHALL be registered into p_data0..p_data3 respectively. The k3 data is captured in the single CAPT cycle (rd_en=0).
REQ-011 In SEND, p_valid SHALL be 1 and p_data0..3 SHALL be held stable until the cycle with p_valid=1 and p_ready=1; the next state SHALL be RESP.
REQ-012 In RESP, p_ans_ready SHALL be 1. p_ans SHALL be captured in the cycle with p_ans_valid=1, and the next state SHALL be WRITE. p_ans_ready SHALL be 0 in all other states, and p_ans_valid outside RESP SHALL be ignored.
REQ-013 WRITE SHALL last one cycle with:
- wr_en=1
- wr_addr = dst + r*OW + c (mod 2^AW)
- wr_data = captured p_ans
REQ-014 After WRITE, the next state SHALL be FETCH for the next window, or FIN after window (OH-1, OW-1).
REQ-015 FIN SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-016 busy SHALL be 1 in FETCH through WRITE and 0 in IDLE and FIN.
REQ-017 start asserted while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-018 With p_ready and p_ans_valid asserted immediately, per-window latency SHALL be 4 FETCH + 1 CAPT + 1 SEND + RESP wait + 1 WRITE cycles.
REQ-019 rd_en, wr_en and p_valid SHALL never be asserted in the same cycle.

Reset
REQ-020 rstn=0 SHALL immediately force IDLE, even mid-run, and SHALL drive these values:
- busy, done, rd_en, wr_en, p_valid, p_ans_ready = 0
- rd_addr, wr_addr, wr_data, p_data0..3 = 0
- window counters = 0
REQ-021 After reset release, no partial window write SHALL occur; the block SHALL wait for a new start.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- 4x4 map with mem[a]=a, src=0, dst=16, ideal pooling model: writes 5,7,13,15 to addresses 16,17,18,19 in order, then one done pulse.
- Backpressure: p_ready held low 3 cycles in SEND -> p_valid stays 1 and p_data0..3 stay unchanged; p_ans_ready held low throughout SEND; write occurs only after result acceptance.
- Dimension edge cases: cfg_w=5, cfg_h=3 -> exactly 2 writes, at dst and dst+1; cfg_w=1 -> done the cycle after start, with zero reads and zero writes.
- Address wrap: src=4094, cfg_w=2, cfg_h=2 (AW=12) -> reads 4094, 4095, 0, 1.
- start pulsed mid-run -> ignored; the write count equals the first run only.
- Reset mid-run, asserted in RESP -> all outputs 0 the same cycle, no write after release; a new start runs cleanly.
